// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types, constants and helpers for the round-robin bus arbiter.
package bus_arbiter_pkg;

  localparam int MAX_MASTERS   = 32;
  localparam int IDX_WIDTH     = 5;
  localparam int COUNTER_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANTED   = 3'd1,
    BUSY      = 3'd2,
    ERROR     = 3'd3,
    FORCE_END = 3'd4
  } arbState_t;

  // One-hot mask for a master index; callers narrow it to their master count.
  function automatic logic [MAX_MASTERS-1:0] onehotMask(input logic [IDX_WIDTH-1:0] index);
    return MAX_MASTERS'(1) << index;
  endfunction

  // Watchdog counters stick at all-ones instead of wrapping.
  function automatic logic [COUNTER_WIDTH-1:0] saturatingIncrement(
    input logic [COUNTER_WIDTH-1:0] value
  );
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant/transaction signals between the bus masters and the arbiter.
interface bus_arbiter_rr_if
  import bus_arbiter_pkg::*;
#(
  parameter int NR_OF_MASTERS = 4
);

  logic [NR_OF_MASTERS-1:0] busRequests;
  logic                     beginTransactionIn;
  logic                     endTransactionIn;
  logic [NR_OF_MASTERS-1:0] busGrants;
  logic                     busErrorOut;
  logic                     endTransactionOut;
  logic [IDX_WIDTH-1:0]     activeMaster;
  logic                     busBusy;

  // Requesters' view: they raise requests and frame transactions.
  modport master (
    output busRequests, beginTransactionIn, endTransactionIn,
    input  busGrants, busErrorOut, endTransactionOut, activeMaster, busBusy
  );

  // Arbiter's view: it consumes requests and hands out grants.
  modport slave (
    input  busRequests, beginTransactionIn, endTransactionIn,
    output busGrants, busErrorOut, endTransactionOut, activeMaster, busBusy
  );

endinterface

// File: rtl/bus_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first requester at or above the pointer, wrapping.
module rr_priority_select
  import bus_arbiter_pkg::*;
#(
  parameter int NR_OF_MASTERS = 4
) (
  input  logic [NR_OF_MASTERS-1:0] requests,
  input  logic [IDX_WIDTH-1:0]     pointer,
  output logic [IDX_WIDTH-1:0]     winner,
  output logic                     anyRequest
);

  localparam int SEL_WIDTH = $clog2(NR_OF_MASTERS);

  // Scan from the pointer upward; the first hit wins and later hits are ignored.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    winner     = '0;
    anyRequest = 1'b0;
    for (int offset = 0; offset < NR_OF_MASTERS; offset++) begin
      int candidate;
      candidate = int'(pointer) + offset;
      if (candidate >= NR_OF_MASTERS) candidate = candidate - NR_OF_MASTERS;
      if (!anyRequest && requests[SEL_WIDTH'(candidate)]) begin
        winner     = IDX_WIDTH'(candidate);
        anyRequest = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared CPU bus with grant and transaction watchdogs.
module bus_arbiter_rr
  import bus_arbiter_pkg::*;
#(
  parameter int NR_OF_MASTERS       = 4,
  parameter int GRANT_TIMEOUT       = 16,
  parameter int TRANSACTION_TIMEOUT = 1024
) (
  input  logic             cpuClock,
  input  logic             cpuReset,
  bus_arbiter_rr_if.slave  bus
);

  localparam logic [COUNTER_WIDTH-1:0] GRANT_LAST = COUNTER_WIDTH'(GRANT_TIMEOUT - 1);
  localparam logic [COUNTER_WIDTH-1:0] TXN_LAST   = COUNTER_WIDTH'(TRANSACTION_TIMEOUT - 1);
  localparam logic [IDX_WIDTH-1:0]     LAST_INDEX = IDX_WIDTH'(NR_OF_MASTERS - 1);

  arbState_t                state;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [IDX_WIDTH-1:0]     pointer;
  logic [IDX_WIDTH-1:0]     winner;
  logic [IDX_WIDTH-1:0]     nextPointer;
  logic                     anyRequest;
  logic                     grantedStillRequesting;

  rr_priority_select #(
    .NR_OF_MASTERS (NR_OF_MASTERS)
  ) prioritySelect (
    .requests   (bus.busRequests),
    .pointer    (pointer),
    .winner     (winner),
    .anyRequest (anyRequest)
  );

  // The pointer moves just past the winner so the winner goes last next round.
  assign nextPointer = (winner == LAST_INDEX) ? '0 : winner + 1'b1;

  // The grant is one-hot, so masking the requests with it isolates the owner's request.
  assign grantedStillRequesting = |(bus.busRequests & bus.busGrants);

  // Arbitration FSM, watchdog counter, rotation pointer and all registered outputs.
  always_ff @(posedge cpuClock or posedge cpuReset) begin
    if (cpuReset) begin
      state                 <= IDLE;
      counter               <= '0;
      pointer               <= '0;
      bus.busGrants         <= '0;
      bus.activeMaster      <= '0;
      bus.busBusy           <= 1'b0;
      bus.busErrorOut       <= 1'b0;
      bus.endTransactionOut <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every branch sees this cycle's state and the
      // pulse defaults below are simply overridden by a later assignment in the same cycle.
      bus.busErrorOut       <= 1'b0;
      bus.endTransactionOut <= 1'b0;
      case (state)
        IDLE: begin
          // beginTransactionIn is a protocol violation here and deliberately ignored.
          if (anyRequest) begin
            state            <= GRANTED;
            bus.busGrants    <= NR_OF_MASTERS'(onehotMask(winner));
            bus.activeMaster <= winner;
            bus.busBusy      <= 1'b1;
            pointer          <= nextPointer;
            counter          <= '0;
          end
        end
        GRANTED: begin
          if (bus.beginTransactionIn) begin
            state   <= BUSY;
            counter <= '0;
          end else if (!grantedStillRequesting || counter == GRANT_LAST) begin
            // No transaction is open, so a stalled master is dropped silently.
            state            <= IDLE;
            bus.busGrants    <= '0;
            bus.activeMaster <= '0;
            bus.busBusy      <= 1'b0;
            counter          <= '0;
          end else begin
            counter <= saturatingIncrement(counter);
          end
        end
        BUSY: begin
          // A real end beats a timeout landing in the same cycle; request drops are ignored.
          if (bus.endTransactionIn) begin
            state            <= IDLE;
            bus.busGrants    <= '0;
            bus.activeMaster <= '0;
            bus.busBusy      <= 1'b0;
            counter          <= '0;
          end else if (counter == TXN_LAST) begin
            state           <= ERROR;
            bus.busErrorOut <= 1'b1;
            bus.busBusy     <= 1'b0;
          end else begin
            counter <= saturatingIncrement(counter);
          end
        end
        ERROR: begin
          // The grant was held through the error cycle; now the bus is forcibly closed.
          state                 <= FORCE_END;
          bus.endTransactionOut <= 1'b1;
          bus.busGrants         <= '0;
          bus.activeMaster      <= '0;
          counter               <= '0;
        end
        FORCE_END: begin
          state <= IDLE;
        end
        default: begin
          state            <= IDLE;
          bus.busGrants    <= '0;
          bus.activeMaster <= '0;
          bus.busBusy      <= 1'b0;
          counter          <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus randomized transactions.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int GT = 16;
  localparam int TT = 8;

  logic cpuClock = 1'b0;
  logic cpuReset;
  int   total    = 0;
  int   bad      = 0;
  int   modelPtr = 0;

  bus_arbiter_rr_if #(.NR_OF_MASTERS(N)) bus ();

  bus_arbiter_rr #(
    .NR_OF_MASTERS       (N),
    .GRANT_TIMEOUT       (GT),
    .TRANSACTION_TIMEOUT (TT)
  ) dut (
    .cpuClock (cpuClock),
    .cpuReset (cpuReset),
    .bus      (bus)
  );

  always #5 cpuClock = ~cpuClock;

  // Advance one cycle and settle just after the rising edge.
  task automatic step();
    @(posedge cpuClock);
    #1;
  endtask

  // Reference rule: rotate the requests so the pointer sits at bit 0, take the lowest set bit.
  function automatic int predictWinner(input logic [N-1:0] req, input int ptr);
    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    doubled = {req, req};
    rotated = N'(doubled >> ptr);
    for (int k = 0; k < N; k++) if (rotated[k]) return (ptr + k) % N;
    return -1;
  endfunction

  // One full grant-to-release episode. beginDelay >= GT means the master never begins;
  // endDelay >= TT means the transaction never ends. Returns in the first IDLE cycle.
  task automatic doTransaction(input logic [N-1:0] req, input int beginDelay,
                               input int endDelay, input bit endInError,
                               input bit shuffleInBusy, input int expectWinner,
                               input string tag);
    int w;
    logic [N-1:0] g;
    bus.busRequests = req;
    step();
    w = predictWinner(req, modelPtr);
    modelPtr = (w + 1) % N;
    g = N'(1 << w);
    total++;
    if (bus.busGrants !== g || bus.activeMaster !== 5'(w) || bus.busBusy !== 1'b1) begin
      bad++;
      $display("FAIL %s grant: got grants=%b master=%0d busy=%b, want grants=%b master=%0d busy=1",
               tag, bus.busGrants, bus.activeMaster, bus.busBusy, g, w);
    end
    if (expectWinner >= 0) begin
      total++;
      if (bus.activeMaster !== 5'(expectWinner)) begin
        bad++;
        $display("FAIL %s winner: got %0d, want %0d", tag, bus.activeMaster, expectWinner);
      end
    end

    if (beginDelay >= GT) begin
      for (int c = 1; c < GT; c++) begin
        step();
        total++;
        if (bus.busGrants !== g || bus.busErrorOut !== 1'b0) begin
          bad++;
          $display("FAIL %s grantHold c=%0d: got grants=%b err=%b, want grants=%b err=0",
                   tag, c, bus.busGrants, bus.busErrorOut, g);
        end
      end
      step();
      total++;
      if (bus.busGrants !== '0 || bus.busBusy !== 1'b0 || bus.busErrorOut !== 1'b0 ||
          bus.activeMaster !== 5'd0) begin
        bad++;
        $display("FAIL %s grantTimeout: got grants=%b busy=%b err=%b master=%0d, want all 0",
                 tag, bus.busGrants, bus.busBusy, bus.busErrorOut, bus.activeMaster);
      end
      return;
    end

    for (int c = 0; c < beginDelay; c++) begin
      step();
      total++;
      if (bus.busGrants !== g || bus.busBusy !== 1'b1) begin
        bad++;
        $display("FAIL %s waitBegin: got grants=%b busy=%b, want grants=%b busy=1",
                 tag, bus.busGrants, bus.busBusy, g);
      end
    end
    bus.beginTransactionIn = 1'b1;
    step();
    bus.beginTransactionIn = 1'b0;

    if (endDelay < TT) begin
      for (int c = 0; c < endDelay; c++) begin
        if (shuffleInBusy) bus.busRequests = N'($urandom_range(0, 15));
        step();
        total++;
        if (bus.busGrants !== g || bus.busBusy !== 1'b1) begin
          bad++;
          $display("FAIL %s busyHold: got grants=%b busy=%b, want grants=%b busy=1",
                   tag, bus.busGrants, bus.busBusy, g);
        end
      end
      bus.endTransactionIn = 1'b1;
      step();
      bus.endTransactionIn = 1'b0;
      total++;
      if (bus.busGrants !== '0 || bus.busBusy !== 1'b0 || bus.busErrorOut !== 1'b0 ||
          bus.endTransactionOut !== 1'b0) begin
        bad++;
        $display("FAIL %s normalEnd: got grants=%b busy=%b err=%b endOut=%b, want all 0",
                 tag, bus.busGrants, bus.busBusy, bus.busErrorOut, bus.endTransactionOut);
      end
      return;
    end

    for (int c = 1; c < TT; c++) begin
      if (shuffleInBusy) bus.busRequests = N'($urandom_range(0, 15));
      step();
      total++;
      if (bus.busGrants !== g || bus.busErrorOut !== 1'b0) begin
        bad++;
        $display("FAIL %s busyWait c=%0d: got grants=%b err=%b, want grants=%b err=0",
                 tag, c, bus.busGrants, bus.busErrorOut, g);
      end
    end
    step();
    total++;
    if (bus.busErrorOut !== 1'b1 || bus.busGrants !== g || bus.busBusy !== 1'b0 ||
        bus.endTransactionOut !== 1'b0) begin
      bad++;
      $display("FAIL %s errorCycle: got err=%b grants=%b busy=%b endOut=%b, want 1 %b 0 0",
               tag, bus.busErrorOut, bus.busGrants, bus.busBusy, bus.endTransactionOut, g);
    end
    if (endInError) bus.endTransactionIn = 1'b1;
    step();
    bus.endTransactionIn = 1'b0;
    total++;
    if (bus.endTransactionOut !== 1'b1 || bus.busGrants !== '0 || bus.busErrorOut !== 1'b0 ||
        bus.activeMaster !== 5'd0) begin
      bad++;
      $display("FAIL %s forceEnd: got endOut=%b grants=%b err=%b master=%0d, want 1 0 0 0",
               tag, bus.endTransactionOut, bus.busGrants, bus.busErrorOut, bus.activeMaster);
    end
    step();
    total++;
    if (bus.endTransactionOut !== 1'b0 || bus.busGrants !== '0 || bus.busErrorOut !== 1'b0 ||
        bus.busBusy !== 1'b0) begin
      bad++;
      $display("FAIL %s afterForce: got endOut=%b grants=%b err=%b busy=%b, want all 0",
               tag, bus.endTransactionOut, bus.busGrants, bus.busErrorOut, bus.busBusy);
    end
  endtask

  task automatic test_reset();
    cpuReset               = 1'b1;
    bus.busRequests        = '0;
    bus.beginTransactionIn = 1'b0;
    bus.endTransactionIn   = 1'b0;
    step();
    step();
    total++;
    if (bus.busGrants !== '0 || bus.activeMaster !== 5'd0 || bus.busBusy !== 1'b0 ||
        bus.busErrorOut !== 1'b0 || bus.endTransactionOut !== 1'b0) begin
      bad++;
      $display("FAIL reset: got grants=%b master=%0d busy=%b err=%b endOut=%b, want all 0",
               bus.busGrants, bus.activeMaster, bus.busBusy, bus.busErrorOut,
               bus.endTransactionOut);
    end
    cpuReset = 1'b0;
    modelPtr = 0;
    step();
  endtask

  task automatic test_rotation();
    for (int i = 0; i < 5; i++) doTransaction(4'b1111, 0, 2, 1'b0, 1'b0, i % N, "rotation");
  endtask

  task automatic test_single();
    doTransaction(4'b0010, 1, 2, 1'b0, 1'b0, 1, "single");
    bus.busRequests = '0;
  endtask

  task automatic test_wrap();
    doTransaction(4'b0100, 0, 1, 1'b0, 1'b0, 2, "wrapSetup");
    doTransaction(4'b0101, 0, 1, 1'b0, 1'b0, 0, "wrapToZero");
    doTransaction(4'b0101, 0, 1, 1'b0, 1'b0, 2, "wrapSkip");
    bus.busRequests = '0;
  endtask

  task automatic test_request_drop();
    int w;
    bus.busRequests = 4'b0100;
    step();
    w = predictWinner(4'b0100, modelPtr);
    modelPtr = (w + 1) % N;
    bus.busRequests = '0;
    step();
    total++;
    if (bus.busGrants !== '0 || bus.busBusy !== 1'b0) begin
      bad++;
      $display("FAIL requestDrop: got grants=%b busy=%b, want 0 0", bus.busGrants, bus.busBusy);
    end
    bus.beginTransactionIn = 1'b1;
    step();
    bus.beginTransactionIn = 1'b0;
    step();
    total++;
    if (bus.busGrants !== '0 || bus.busBusy !== 1'b0) begin
      bad++;
      $display("FAIL beginInIdle: got grants=%b busy=%b, want 0 0", bus.busGrants, bus.busBusy);
    end
    doTransaction(4'b1111, 0, 0, 1'b0, 1'b0, (w + 1) % N, "afterDrop");
    bus.busRequests = '0;
  endtask

  task automatic test_grant_timeout();
    doTransaction(4'b0100, GT, 0, 1'b0, 1'b0, 2, "grantTimeout");
    bus.busRequests = '0;
  endtask

  task automatic test_txn_timeout();
    doTransaction(4'b1000, 0, TT, 1'b0, 1'b0, 3, "txnTimeout");
    doTransaction(4'b1000, 2, TT, 1'b1, 1'b0, 3, "endInErrorIgnored");
    doTransaction(4'b0001, 0, TT - 1, 1'b0, 1'b0, 0, "endOnTimeoutCycle");
    bus.busRequests = '0;
  endtask

  task automatic test_async_reset();
    bus.busRequests = 4'b0010;
    step();
    bus.beginTransactionIn = 1'b1;
    step();
    bus.beginTransactionIn = 1'b0;
    step();
    #3 cpuReset = 1'b1;
    #1;
    total++;
    if (bus.busGrants !== '0 || bus.busBusy !== 1'b0 || bus.activeMaster !== 5'd0 ||
        bus.busErrorOut !== 1'b0 || bus.endTransactionOut !== 1'b0) begin
      bad++;
      $display("FAIL asyncReset: got grants=%b busy=%b master=%0d err=%b endOut=%b, want all 0",
               bus.busGrants, bus.busBusy, bus.activeMaster, bus.busErrorOut,
               bus.endTransactionOut);
    end
    bus.busRequests = '0;
    step();
    cpuReset = 1'b0;
    modelPtr = 0;
    doTransaction(4'b1010, 0, 0, 1'b0, 1'b0, 1, "pointerAfterReset");
    doTransaction(4'b1000, 0, 0, 1'b0, 1'b0, 3, "master3AfterReset");
    bus.busRequests = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] req;
      int bd, ed, r;
      req = N'($urandom_range(1, 15));
      bd  = ($urandom_range(0, 9) == 0) ? GT : int'($urandom_range(0, 4));
      r   = int'($urandom_range(0, 9));
      ed  = (r < 2) ? TT : (r == 2) ? TT - 1 : int'($urandom_range(0, 4));
      doTransaction(req, bd, ed, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1,
                    "random");
      if ($urandom_range(0, 3) == 0) begin
        bus.busRequests = '0;
        step();
        total++;
        if (bus.busGrants !== '0 || bus.busBusy !== 1'b0) begin
          bad++;
          $display("FAIL randomIdle: got grants=%b busy=%b, want 0 0",
                   bus.busGrants, bus.busBusy);
        end
      end
    end
    bus.busRequests = '0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_wrap();
    test_request_drop();
    test_grant_timeout();
    test_txn_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter for the shared CPU bus.
- Takes request lines from bus masters (instruction fetch, data cache, DMA, …) and issues one-hot registered grants.
- Tracks each granted transaction from beginTransaction to endTransaction.
- Watchdogs recover the bus from masters that never start a transaction and from transactions that never end, by signalling busError and forcing endTransaction.

Parameters:
- NR_OF_MASTERS, 4, number of requesters; legal range 2..32.
- GRANT_TIMEOUT, 16, cycles a granted master may wait before it must assert beginTransactionIn.
- TRANSACTION_TIMEOUT, 1024, maximum cycles from beginTransaction to endTransaction; legal range 2..65535.

Ports:
- cpuClock  in  1  system clock; all state updates on rising edge.
- cpuReset  in  1  asynchronous, active-high reset.
- busRequests  in  NR_OF_MASTERS  level request, bit i = master i; held until transaction done.
- beginTransactionIn  in  1  OR of all masters' beginTransaction.
- endTransactionIn  in  1  OR of all masters'/slaves' endTransaction.
- busGrants  out  NR_OF_MASTERS  one-hot or zero grant, registered.
- busErrorOut  out  1  one-cycle bus error pulse on timeout.
- endTransactionOut  out  1  one-cycle forced end after a timeout error.
- activeMaster  out  5  index of the granted master; 0 when none is granted.
- busBusy  out  1  high in GRANTED and BUSY.

Behaviour:
- Reset (async): state IDLE, busGrants 0, pointer 0, counter 0, busErrorOut 0, endTransactionOut 0, activeMaster 0, busBusy 0.
- States: IDLE, GRANTED, BUSY, ERROR, FORCE_END. Encoding lives in the package.
- Arbitration: combinational winner is the first set bit of busRequests found by searching upward from pointer, with wrap-around (index NR_OF_MASTERS-1 is followed by 0).
- IDLE:
  - If any request is set: next cycle busGrants = onehot(winner), activeMaster = winner, pointer = (winner+1) mod NR_OF_MASTERS, counter cleared, go to GRANTED.
  - Latency: request visible in cycle t gives the grant in cycle t+1.
- GRANTED:
  - beginTransactionIn=1 → BUSY, counter cleared.
  - Else if request bit of activeMaster drops → IDLE, grant removed next cycle.
  - Else counter increments. When counter == GRANT_TIMEOUT-1 → IDLE and grant removed; no error pulse, because no transaction is open.
- BUSY:
  - endTransactionIn=1 → IDLE, grant removed next cycle. One IDLE turnaround cycle is mandatory before the next grant.
  - Else counter increments. When counter == TRANSACTION_TIMEOUT-1 → ERROR.
  - endTransactionIn and timeout in the same cycle: the normal end wins; no error.
  - Request drop during BUSY is ignored; the grant holds until the end.
- ERROR:
  - busErrorOut=1 for exactly one cycle; grant still held so the master sees the error.
  - Next state FORCE_END.
- FORCE_END:
  - endTransactionOut=1 for one cycle; grant removed; next state IDLE.
  - endTransactionIn arriving in ERROR is ignored; FORCE_END still occurs.
- busErrorOut and endTransactionOut are registered, state-decoded, and never high outside ERROR / FORCE_END respectively.
- busBusy = state ∈ {GRANTED, BUSY}. Grants are only ever held in GRANTED, BUSY and ERROR.
- Counter is 16-bit and saturates; it never wraps inside a state.
- The pointer advances only on a grant, so a master that releases early does not lose its rotation slot fairness.
- beginTransactionIn in IDLE is ignored (protocol violation, no state change).
- Reset asserted mid-transaction: all outputs return to reset values immediately, independent of clock.

Decomposition:
- Package bus_arbiter_pkg:
  - state localparams IDLE=0, GRANTED=1, BUSY=2, ERROR=3, FORCE_END=4;
  - counter width constant 16;
  - a function computing the one-hot mask from an index.
- Sub-module rr_priority_select: combinational; inputs requests + pointer; outputs winner index + anyRequest.
- The remainder (FSM, counter, pointer, output registers) stays in bus_arbiter_rr.

Test Plan:
- Single requester: busRequests=4'b0010 at t → busGrants=0010 and activeMaster=1 at t+1. Begin at t+2, end at t+5 → grants 0 at t+6, IDLE at t+6.
- Rotation: all four requesting continuously, each transaction begin+end after 3 cycles → grant order 0,1,2,3,0 with one idle cycle between grants.
- Wrap and skip: pointer=3, busRequests=4'b0101 → master 0 granted, pointer becomes 1. Next round with same requests → master 2 granted.
- Grant timeout: grant master 2, no begin for 16 cycles → grant dropped on cycle 17, busErrorOut stays 0, state IDLE.
- Transaction timeout, TRANSACTION_TIMEOUT=8: begin, no end → busErrorOut pulse in the 9th cycle after begin, endTransactionOut pulse the next cycle with grant 0, then IDLE. Repeat with end on the timeout cycle → no error.
- Async reset while BUSY: assert cpuReset between clock edges → busGrants, busBusy, activeMaster go 0 without a clock edge. After release, request from master 3 → granted in one cycle, pointer starting at 0.
